// File: rtl/updown_counter_pkg.sv
// Shared constants for the parametrised up/down counter.
// Optional build macro: UPDOWN_COUNTER_STICKY_OVF_EN (see updown_counter_mod).
package updown_counter_pkg;

  // Values of the mode input.
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Values of the direction input.
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

endpackage : updown_counter_pkg

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with wrap/saturate modes, clamped parallel load,
// terminal decodes and a registered wrap pulse.
// Define UPDOWN_COUNTER_STICKY_OVF_EN to add ovf_clear/ovf_sticky, a sticky flag
// that records wraps and blocked saturate steps.
module updown_counter_mod
  import updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_COUNT = 32'((64'd1 << WIDTH) - 64'd1),
  parameter int unsigned RST_VALUE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             direction,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
`ifdef UPDOWN_COUNTER_STICKY_OVF_EN
  input  logic             ovf_clear,
  output logic             ovf_sticky,
`endif
  output logic [WIDTH-1:0] counter_out,
  output logic             at_max,
  output logic             at_min,
  output logic             wrapped
);

  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RST_C  = WIDTH'(RST_VALUE);
  localparam logic [WIDTH-1:0] ZERO_C = '0;
  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrapped_q, wrapped_d;
  logic             at_max_c, at_min_c;
  logic             blocked_c;

  // Terminal decodes of the count register; bounds are checked before any
  // arithmetic so the step never overflows WIDTH bits.
  assign at_max_c = (count_q == MAX_C);
  assign at_min_c = (count_q == ZERO_C);

  // Next count and wrap pulse; priority load > enable > hold (reset in the flop).
  always_comb begin
    count_d   = count_q;
    wrapped_d = 1'b0;
    blocked_c = 1'b0;
    if (load) begin
      count_d = (load_value > MAX_C) ? MAX_C : load_value;
    end else if (enable) begin
      if (direction == DIR_UP) begin
        if (!at_max_c) begin
          count_d = count_q + ONE_C;
        end else if (mode == MODE_WRAP) begin
          count_d   = ZERO_C;
          wrapped_d = 1'b1;
        end else begin
          blocked_c = 1'b1;
        end
      end else begin
        if (!at_min_c) begin
          count_d = count_q - ONE_C;
        end else if (mode == MODE_WRAP) begin
          count_d   = MAX_C;
          wrapped_d = 1'b1;
        end else begin
          blocked_c = 1'b1;
        end
      end
    end
  end

  // Count and wrap-pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= RST_C;
      wrapped_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      wrapped_q <= wrapped_d;
    end
  end

`ifdef UPDOWN_COUNTER_STICKY_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky overflow: a new wrap or blocked step wins over a clear request.
  always_comb begin
    ovf_d = ovf_q;
    if (wrapped_d || blocked_c) begin
      ovf_d = 1'b1;
    end else if (ovf_clear) begin
      ovf_d = 1'b0;
    end
  end

  // Sticky overflow register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_sticky = ovf_q;
`else
  logic unused_blocked;
  assign unused_blocked = blocked_c;
`endif

  assign counter_out = count_q;
  assign at_max      = at_max_c;
  assign at_min      = at_min_c;
  assign wrapped     = wrapped_q;

endmodule : updown_counter_mod

// File: tb/tb_updown_counter_mod.sv
// Directed self-checking bench for updown_counter_mod (WIDTH=8, MAX_COUNT=9).
// Sticky-flag steps run when UPDOWN_COUNTER_STICKY_OVF_EN is defined.
module tb_updown_counter_mod;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned MAXC  = 9;

  logic             clk = 1'b0;
  logic             rst, enable, direction, mode, load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] counter_out;
  logic             at_max, at_min, wrapped;
`ifdef UPDOWN_COUNTER_STICKY_OVF_EN
  logic             ovf_clear, ovf_sticky;
`endif

  int n_cmp = 0;
  int n_err = 0;

  updown_counter_mod #(.WIDTH(WIDTH), .MAX_COUNT(MAXC), .RST_VALUE(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .direction   (direction),
    .mode        (mode),
    .load        (load),
    .load_value  (load_value),
`ifdef UPDOWN_COUNTER_STICKY_OVF_EN
    .ovf_clear   (ovf_clear),
    .ovf_sticky  (ovf_sticky),
`endif
    .counter_out (counter_out),
    .at_max      (at_max),
    .at_min      (at_min),
    .wrapped     (wrapped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int cnt, input logic wr);
    chk({tag, ".count"}, 32'(counter_out), 32'(cnt));
    chk({tag, ".wrapped"}, 32'(wrapped), 32'(wr));
  endtask

  task automatic do_load(input int v);
    load = 1'b1; load_value = WIDTH'(v);
    step();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; direction = 1'b1; mode = 1'b0;
    load = 1'b0; load_value = '0;
`ifdef UPDOWN_COUNTER_STICKY_OVF_EN
    ovf_clear = 1'b0;
`endif
    step(); step();
    rst = 1'b0;
    chk_state("reset", 0, 1'b0);
    chk("reset.at_min", 32'(at_min), 32'd1);
    chk("reset.at_max", 32'(at_max), 32'd0);

    // Wrap mode, count up 1..9 then wrap to 0.
    enable = 1'b1; direction = 1'b1; mode = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step();
      chk_state("up", i, 1'b0);
      chk("up.at_max", 32'(at_max), (i == 9) ? 32'd1 : 32'd0);
    end
    step();
    chk_state("up_wrap", 0, 1'b1);
    chk("up_wrap.at_min", 32'(at_min), 32'd1);
    step();
    chk_state("up_after_wrap", 1, 1'b0);

    // Wrap mode, count down from 0.
    enable = 1'b0;
    do_load(0);
    chk("dn.at_min", 32'(at_min), 32'd1);
    enable = 1'b1; direction = 1'b0;
    step(); chk_state("dn_wrap", 9, 1'b1);
    step(); chk_state("dn8", 8, 1'b0);
    step(); chk_state("dn7", 7, 1'b0);

    // Saturate up from 7.
    enable = 1'b0;
    do_load(7);
    enable = 1'b1; direction = 1'b1; mode = 1'b1;
    step(); chk_state("sat_up8", 8, 1'b0);
    step(); chk_state("sat_up9", 9, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(); chk_state("sat_hold9", 9, 1'b0);
    end
    // Saturate down at 0.
    enable = 1'b0;
    do_load(0);
    enable = 1'b1; direction = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); chk_state("sat_hold0", 0, 1'b0);
    end

    // Loads.
    enable = 1'b0; mode = 1'b0;
    do_load(5);   chk_state("load5", 5, 1'b0);
    step();       chk_state("hold5", 5, 1'b0);
    do_load(200); chk_state("load_clamp", 9, 1'b0);
    enable = 1'b1; direction = 1'b1;
    do_load(3);   chk_state("load_vs_en", 3, 1'b0);
    // Load at 9 in wrap-up: load must beat the pending wrap.
    enable = 1'b0;
    do_load(9);
    enable = 1'b1;
    do_load(9);   chk_state("load_no_wrap", 9, 1'b0);

    // Reset mid-count with load and enable.
    enable = 1'b0;
    do_load(6);
    rst = 1'b1; load = 1'b1; load_value = WIDTH'(4); enable = 1'b1;
    step();
    rst = 1'b0; load = 1'b0;
    chk_state("rst_mid", 0, 1'b0);
    // Reset coincident with a would-be wrap.
    enable = 1'b0;
    do_load(9);
    rst = 1'b1; enable = 1'b1; direction = 1'b1; mode = 1'b0;
    step();
    rst = 1'b0;
    chk_state("rst_vs_wrap", 0, 1'b0);

`ifdef UPDOWN_COUNTER_STICKY_OVF_EN
    chk("ovf.reset", 32'(ovf_sticky), 32'd0);
    enable = 1'b0;
    do_load(9);
    enable = 1'b1;
    step();
    chk_state("ovf_wrap", 0, 1'b1);
    chk("ovf.set", 32'(ovf_sticky), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      step(); chk("ovf.hold", 32'(ovf_sticky), 32'd1);
    end
    enable = 1'b0; ovf_clear = 1'b1;
    step(); ovf_clear = 1'b0;
    chk("ovf.clear", 32'(ovf_sticky), 32'd0);
    do_load(9);
    enable = 1'b1; ovf_clear = 1'b1;
    step(); ovf_clear = 1'b0;
    chk("ovf.set_wins", 32'(ovf_sticky), 32'd1);
    enable = 1'b0; ovf_clear = 1'b1;
    step(); ovf_clear = 1'b0;
    chk("ovf.clear2", 32'(ovf_sticky), 32'd0);
    do_load(9);
    mode = 1'b1; enable = 1'b1;
    step();
    chk("ovf.sat_block", 32'(ovf_sticky), 32'd1);
    enable = 1'b0; mode = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_updown_counter_mod

// File: doc/updown_counter_mod.md
Name: updown_counter_mod

Overview:
Parametrised up/down counter that succeeds the fixed 8-bit up/down counter.
- Generalises width and terminal count (modulus).
- Adds wrap and saturate modes, synchronous parallel load, and terminal/wrap status flags.
- Used as the shared counting primitive for timers, address sequencers and PWM blocks.

Parameters:
WIDTH, 8, counter width in bits (2..32)
MAX_COUNT, 2**WIDTH-1, terminal count; valid range 0..MAX_COUNT; must be ≥1 and ≤ 2**WIDTH-1
RST_VALUE, 0, value loaded on reset; must be ≤ MAX_COUNT

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
enable  input  1  count enable
direction  input  1  1 = count up, 0 = count down
mode  input  1  0 = wrap, 1 = saturate
load  input  1  synchronous parallel load strobe
load_value  input  WIDTH  value to load
counter_out  output  WIDTH  current count (registered)
at_max  output  1  counter_out == MAX_COUNT (combinational decode of the register)
at_min  output  1  counter_out == 0 (combinational decode of the register)
wrapped  output  1  registered one-cycle pulse; high in the cycle the wrapped value appears on counter_out

Behaviour:
- Priority per rising edge: rst > load > enable > hold.
- Reset values:
  - counter_out = RST_VALUE; wrapped = 0.
  - at_max and at_min follow the decode of counter_out.
- Load:
  - counter_out <= load_value when load_value ≤ MAX_COUNT, else MAX_COUNT (clamped).
  - wrapped <= 0. Load takes effect regardless of enable.
- Enable with direction=1:
  - Below MAX_COUNT: counter_out +1.
  - At MAX_COUNT, wrap mode: counter_out <= 0, wrapped <= 1.
  - At MAX_COUNT, saturate mode: hold, wrapped <= 0.
- Enable with direction=0:
  - Above 0: counter_out -1.
  - At 0, wrap mode: counter_out <= MAX_COUNT, wrapped <= 1.
  - At 0, saturate mode: hold, wrapped <= 0.
- enable=0 with no load or rst: hold counter_out; wrapped <= 0.
- Latency: one cycle from input sample to counter_out change. No combinational path from inputs to counter_out.
- direction and mode may change on any cycle; the new value applies at the next edge.
- Arithmetic:
  - Next-value computation is WIDTH bits wide.
  - Internal compare against MAX_COUNT is done before increment, so no overflow beyond WIDTH is ever produced.
- Reset asserted mid-count or coincident with load or enable: reset wins, and wrapped is cleared that cycle.
- MAX_COUNT=1: counter toggles 0/1. In wrap mode every enabled step except 0→1 (up) or 1→0 (down) is a wrap.

Optional Feature:
Macro: UPDOWN_COUNTER_STICKY_OVF_EN
- Defined:
  - Adds input ovf_clear (1) and output ovf_sticky (1).
  - ovf_sticky sets on any cycle where wrapped is set, or where a saturate-mode step is blocked at a bound.
  - ovf_sticky clears on rst, or on ovf_clear when no new set event occurs that cycle; set wins over clear.
  - ovf_sticky resets to 0.
- Undefined: neither port exists and there is no extra logic.

Decomposition:
- Package updown_counter_pkg holds the mode constants MODE_WRAP=1'b0 and MODE_SAT=1'b1, and DIR_UP/DIR_DOWN constants.
- Single module; no sub-module is natural. The next-value logic stays as one combinational block feeding the count register.

Test Plan:
- WIDTH=8, MAX_COUNT=9, wrap, direction=1, enable=1 from reset: sequence 0..9, then 0.
  - wrapped high only with the 9→0 transition.
  - at_max high while counter_out=9.
- Same config, direction=0 from 0: next value is 9 with wrapped=1, then 8, 7.
  - at_min high at 0.
- Saturate mode: up from 7 to 9 then holds at 9 for 3 cycles; down from 0 holds at 0; wrapped never asserts.
- Load tests:
  - load_value=5 with enable=0: counter_out=5 next cycle.
  - load_value=200 with MAX_COUNT=9: counter_out=9.
  - load and enable together: loaded value, no step.
- rst asserted mid-count at 6 together with load=1 and enable=1: counter_out=RST_VALUE (0) next cycle, wrapped=0.
- With UPDOWN_COUNTER_STICKY_OVF_EN:
  - Wrap 9→0 sets ovf_sticky; it stays set through 4 further counts.
  - ovf_clear drops it next cycle.
  - Simultaneous clear and wrap keeps it set.
